// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result streamer.
//   N_BINS_DEF / DW_DEF : default FFT length and component width
//   PAIR_W_DEF          : pair-index width for the default FFT length
//   streamer_state_t    : streamer FSM encoding
//   bitrev()            : reverses the low 'width' bits of an index
package fft_pkg;

  localparam int unsigned N_BINS_DEF = 1024;
  localparam int unsigned DW_DEF     = 16;
  localparam int unsigned PAIR_W_DEF = $clog2(N_BINS_DEF) - 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } streamer_state_t;

  // Only called with elaboration-time constant widths, so the loop unrolls.
  function automatic logic [31:0] bitrev(input logic [31:0] b, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < width; i++) begin
      r[i] = b[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with asynchronous clear.
//   clk, reset_fft : clock, async active-high clear
//   din            : W-bit input, sampled every cycle
//   dout           : din delayed by DEPTH cycles
module pipe_delay #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset_fft,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge reset_fft) begin
    if (reset_fft) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fft_bin_streamer.sv
// Streams one completed FFT frame out of the dual-port result RAM as bin
// pairs (2p, 2p+1), one pair per cycle, toward the peak detector.
//   clk, reset_fft          : clock, async active-high reset (frame scoped)
//   fft_done                : pulse, RAM holds a complete frame
//   ram_rd_en               : read strobe for both RAM ports
//   ram_addr0 / ram_addr1   : even / odd bin addresses (bit-reversed if BITREV)
//   ram_rdata0 / ram_rdata1 : {real, imag} read data, RAM_LAT cycles after address
//   output_index            : pair index p of the presented data
//   real0/imag0, real1/imag1: bins 2p and 2p+1, zero when not valid
//   bin_valid               : presented pair is valid
//   busy                    : frame being read or drained
//   stream_done             : frame fully presented, held until reset
module fft_bin_streamer
  import fft_pkg::*;
#(
  parameter int unsigned N_BINS    = N_BINS_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned RAM_LAT   = 1,
  parameter int unsigned HALF_ONLY = 1,
  parameter int unsigned BITREV    = 1
) (
  input  logic                            clk,
  input  logic                            reset_fft,
  input  logic                            fft_done,
  output logic                            ram_rd_en,
  output logic        [$clog2(N_BINS)-1:0] ram_addr0,
  output logic        [$clog2(N_BINS)-1:0] ram_addr1,
  input  logic        [2*DW-1:0]           ram_rdata0,
  input  logic        [2*DW-1:0]           ram_rdata1,
  output logic        [$clog2(N_BINS)-2:0] output_index,
  output logic signed [DW-1:0]             real0,
  output logic signed [DW-1:0]             imag0,
  output logic signed [DW-1:0]             real1,
  output logic signed [DW-1:0]             imag1,
  output logic                            bin_valid,
  output logic                            busy,
  output logic                            stream_done
);

  localparam int unsigned AW      = $clog2(N_BINS);
  localparam int unsigned PW      = AW - 1;
  localparam int unsigned N_PAIRS = (HALF_ONLY != 0) ? N_BINS / 4 : N_BINS / 2;
  localparam logic [PW-1:0] P_LAST     = PW'(N_PAIRS - 1);
  localparam logic [2:0]    DRAIN_LAST = 3'(RAM_LAT - 1);

  streamer_state_t state_q, state_d;
  logic [PW-1:0]   pair_q;
  logic [2:0]      drain_q;
  logic            rd_en;
  logic [AW-1:0]   bin0, bin1;
  logic [PW:0]     align_out;
  logic            dly_valid;
  logic [PW-1:0]   dly_pair;

  always_ff @(posedge clk or posedge reset_fft) begin
    if (reset_fft) begin
      state_q <= IDLE;
      pair_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && fft_done) begin
        pair_q <= '0;
      end else if (state_q == READ && pair_q != P_LAST) begin
        pair_q <= pair_q + PW'(1);
      end
      drain_q <= (state_q == DRAIN) ? drain_q + 3'd1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE:  if (fft_done) state_d = READ;
      READ: begin
        rd_en = 1'b1;
        if (pair_q == P_LAST) state_d = DRAIN;
      end
      DRAIN: if (drain_q == DRAIN_LAST) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign bin0 = {pair_q, 1'b0};
  assign bin1 = {pair_q, 1'b1};

  always_comb begin
    ram_addr0 = '0;
    ram_addr1 = '0;
    if (rd_en) begin
      if (BITREV != 0) begin
        ram_addr0 = AW'(bitrev(32'(bin0), AW));
        ram_addr1 = AW'(bitrev(32'(bin1), AW));
      end else begin
        ram_addr0 = bin0;
        ram_addr1 = bin1;
      end
    end
  end

  assign ram_rd_en   = rd_en;
  assign busy        = (state_q == READ) || (state_q == DRAIN);
  assign stream_done = (state_q == DONE);

  // Issue strobe and pair index ride alongside the RAM read so the index
  // lines up with the returning data.
  pipe_delay #(
    .W     (PW + 1),
    .DEPTH (RAM_LAT)
  ) u_align (
    .clk       (clk),
    .reset_fft (reset_fft),
    .din       ({rd_en, pair_q}),
    .dout      (align_out)
  );

  assign dly_valid = align_out[PW];
  assign dly_pair  = align_out[PW-1:0];

  // Zeroing when invalid keeps the detector's magnitude at 0 outside the frame.
  assign bin_valid    = dly_valid;
  assign output_index = dly_valid ? dly_pair : '0;
  assign real0        = dly_valid ? ram_rdata0[2*DW-1:DW] : '0;
  assign imag0        = dly_valid ? ram_rdata0[DW-1:0]    : '0;
  assign real1        = dly_valid ? ram_rdata1[2*DW-1:DW] : '0;
  assign imag1        = dly_valid ? ram_rdata1[DW-1:0]    : '0;

endmodule
